// File: rtl/fc_l2_port_arbiter_if.sv
// Bundle of requester-side and L2-side TCDM signals around the FC L2 port arbiter.
// Handshake: a request is accepted on a cycle where req and gnt are both high; responses return in order, one per r_valid.
interface fc_l2_port_arbiter_if #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [N_PORTS-1:0]            s_req_i;
    logic [N_PORTS*ADDR_WIDTH-1:0] s_add_i;
    logic [N_PORTS-1:0]            s_wen_i;
    logic [N_PORTS*DATA_WIDTH-1:0] s_wdata_i;
    logic [N_PORTS*BE_WIDTH-1:0]   s_be_i;
    logic [N_PORTS-1:0]            s_gnt_o;
    logic [N_PORTS-1:0]            s_r_valid_o;
    logic [DATA_WIDTH-1:0]         s_r_rdata_o;
    logic                          s_r_opc_o;

    logic                          m_req_o;
    logic [ADDR_WIDTH-1:0]         m_add_o;
    logic                          m_wen_o;
    logic [DATA_WIDTH-1:0]         m_wdata_o;
    logic [BE_WIDTH-1:0]           m_be_o;
    logic                          m_gnt_i;
    logic                          m_r_valid_i;
    logic [DATA_WIDTH-1:0]         m_r_rdata_i;
    logic                          m_r_opc_i;

    // Arbiter view: it is the L2 master and the slave of every requester.
    modport master (
        input  s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
        input  m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i,
        output s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
        output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o
    );

    modport slave (
        output s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
        output m_gnt_i, m_r_valid_i, m_r_rdata_i, m_r_opc_i,
        input  s_gnt_o, s_r_valid_o, s_r_rdata_o, s_r_opc_o,
        input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o
    );
endinterface

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one FC L2 TCDM master port between N requesters,
// with request locking until grant and in-order response steering via an ID FIFO.
module fc_l2_port_arbiter #(
    parameter int N_PORTS         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    fc_l2_port_arbiter_if.master               bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o,
    output logic                               dbg_locked_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = PTR_W + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_PORTS - 1);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e      state_q;
    logic [ID_W-1:0]  locked_id_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  id_fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  head_id;
    logic             any_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req;
    logic             handshake;
    logic             pop;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_PORTS) s = s - N_PORTS;
        return ID_W'(s);
    endfunction

    // Descending scan so the port closest to rr_ptr is the last (winning) assignment.
    always_comb begin : winner_select
        winner = rr_ptr_q;
        if (state_q == ST_LOCKED) begin
            winner = locked_id_q;
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (bus.s_req_i[rr_index(rr_ptr_q, i)]) winner = rr_index(rr_ptr_q, i);
            end
        end
    end

    assign any_req    = |bus.s_req_i;
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    // rst_ni gates the request so the L2 side sees it drop the moment reset asserts.
    assign req        = rst_ni & (any_req | (state_q == ST_LOCKED)) & ~fifo_full;
    assign handshake  = req & bus.m_gnt_i;
    assign pop        = bus.m_r_valid_i & ~fifo_empty;
    assign head_id    = id_fifo_q[rd_ptr_q];

    always_comb begin : port_outputs
        bus.m_req_o   = req;
        bus.m_add_o   = '0;
        bus.m_wen_o   = 1'b0;
        bus.m_wdata_o = '0;
        bus.m_be_o    = '0;
        if (req) begin
            bus.m_add_o   = bus.s_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.m_wen_o   = bus.s_wen_i[winner];
            bus.m_wdata_o = bus.s_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
            bus.m_be_o    = bus.s_be_i[winner*BE_WIDTH +: BE_WIDTH];
        end
        bus.s_gnt_o             = '0;
        bus.s_gnt_o[winner]     = handshake;
        bus.s_r_valid_o         = '0;
        bus.s_r_valid_o[head_id] = pop;
        bus.s_r_rdata_o         = bus.m_r_rdata_i;
        bus.s_r_opc_o           = bus.m_r_opc_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_OPEN;
            locked_id_q <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) id_fifo_q[i] <= '0;
        end else begin
            if (handshake) begin
                state_q             <= ST_OPEN;
                rr_ptr_q            <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
                id_fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end else if (req) begin
                // Presented but not granted: pin the winner until L2 accepts it.
                state_q     <= ST_LOCKED;
                locked_id_q <= winner;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (bus.m_r_valid_i && fifo_empty) err_q <= 1'b1;
            case ({handshake, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
    assign dbg_locked_o  = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Randomized bench for fc_l2_port_arbiter: queue-based reference model for arbitration,
// an L2 responder, and a response scoreboard fed at grant time and drained by a monitor.
module tb_fc_l2_port_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int EW = 8 + 1 + DW;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [$clog2(MO):0] outstanding;
    logic err;
    logic dbg_locked;

    fc_l2_port_arbiter_if #(.N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fc_l2_port_arbiter #(
        .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .outstanding_o (outstanding),
        .err_o         (err),
        .dbg_locked_o  (dbg_locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // requester state: a raised request holds its payload until granted
    bit            rq [N];
    logic [AW-1:0] ra [N];
    logic          rw [N];
    logic [DW-1:0] rd [N];
    logic [BW-1:0] rb [N];

    // reference model
    int             rr;
    bit             lk;
    int             lk_id;
    bit             err_m;
    int             out_q [$];
    logic [DW:0]    l2_q [$];
    logic [EW-1:0]  exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit any_rq();
        for (int k = 0; k < N; k++) if (rq[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_winner();
        if (lk) return lk_id;
        for (int i = 0; i < N; i++) begin
            int p = (rr + i) % N;
            if (rq[p]) return p;
        end
        return rr;
    endfunction

    task automatic drive_requests();
        for (int k = 0; k < N; k++) begin
            bus.s_req_i[k]               = rq[k];
            bus.s_add_i[k*AW +: AW]      = ra[k];
            bus.s_wen_i[k]               = rw[k];
            bus.s_wdata_i[k*DW +: DW]    = rd[k];
            bus.s_be_i[k*BW +: BW]       = rb[k];
        end
    endtask

    task automatic model_reset();
        rr = 0;
        lk = 1'b0;
        lk_id = 0;
        err_m = 1'b0;
        out_q.delete();
        l2_q.delete();
        exp_q.delete();
    endtask

    // One clock of stimulus, per-cycle checks and reference-model update.
    task automatic cycle(input int p_req, input int p_gnt, input int p_rsp, input bit stale);
        int w;
        bit exp_req, hs, rv;
        logic [DW:0] rsp;
        logic [DW-1:0] nd;
        logic no;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (!rq[k] && ($urandom_range(0, 99) < p_req)) begin
                rq[k] = 1'b1;
                ra[k] = $urandom;
                rw[k] = 1'($urandom_range(0, 1));
                rd[k] = $urandom;
                rb[k] = 4'($urandom_range(0, 15));
            end
        end
        drive_requests();
        bus.m_gnt_i = ($urandom_range(0, 99) < p_gnt);
        rv = 1'b0;
        rsp = '0;
        if (stale && out_q.size() == 0) begin
            rv = 1'b1;
            rsp = {1'($urandom_range(0, 1)), DW'($urandom)};
        end else if (l2_q.size() > 0 && ($urandom_range(0, 99) < p_rsp)) begin
            rv = 1'b1;
            rsp = l2_q.pop_front();
        end
        bus.m_r_valid_i = rv;
        bus.m_r_rdata_i = rsp[DW-1:0];
        bus.m_r_opc_i   = rsp[DW];
        #1;
        exp_req = (any_rq() || lk) && (out_q.size() < MO);
        w = model_winner();
        hs = exp_req && bus.m_gnt_i;
        chk("m_req", 64'(bus.m_req_o), 64'(exp_req));
        if (exp_req) begin
            chk("m_add", 64'(bus.m_add_o), 64'(ra[w]));
            chk("m_wen_wdata_be", 64'({bus.m_wen_o, bus.m_wdata_o, bus.m_be_o}), 64'({rw[w], rd[w], rb[w]}));
        end else begin
            chk("idle_add", 64'(bus.m_add_o), 64'(0));
            chk("idle_wen_wdata_be", 64'({bus.m_wen_o, bus.m_wdata_o, bus.m_be_o}), 64'(0));
        end
        chk("s_gnt", 64'(bus.s_gnt_o), hs ? (64'(1) << w) : 64'(0));
        chk("rvalid_any", 64'(|bus.s_r_valid_o), 64'(rv && out_q.size() > 0));
        chk("outstanding", 64'(outstanding), 64'(out_q.size()));
        chk("err", 64'(err), 64'(err_m));
        chk("dbg_locked", 64'(dbg_locked), 64'(lk));
        @(posedge clk);
        if (rv) begin
            if (out_q.size() > 0) void'(out_q.pop_front());
            else err_m = 1'b1;
        end
        if (hs) begin
            nd = $urandom;
            no = ($urandom_range(0, 9) == 0);
            out_q.push_back(w);
            l2_q.push_back({no, nd});
            exp_q.push_back({8'(w), no, nd});
            rr = (w + 1) % N;
            lk = 1'b0;
            rq[w] = 1'b0;
        end else if (exp_req) begin
            lk = 1'b1;
            lk_id = w;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #3 rst_ni = 1'b0;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_m_req", 64'(bus.m_req_o), 64'(0));
        chk("rst_s_gnt", 64'(bus.s_gnt_o), 64'(0));
        model_reset();
        @(negedge clk);
        bus.s_req_i     = '0;
        bus.m_gnt_i     = 1'b0;
        bus.m_r_valid_i = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (out_q.size() == 0 && !any_rq()) done = 1'b1;
            else cycle(0, 100, 100, 1'b0);
        end
        chk("drain_done", 64'(done), 64'(1));
    endtask

    // Response monitor: every DUT response must match the oldest expected one.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (|bus.s_r_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.s_r_valid_o), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_port", 64'(bus.s_r_valid_o), 64'(1) << e[EW-1 -: 8]);
                    chk("rsp_rdata", 64'(bus.s_r_rdata_o), 64'(e[DW-1:0]));
                    chk("rsp_opc", 64'(bus.s_r_opc_o), 64'(e[DW]));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rq[k] = 1'b0; ra[k] = '0; rw[k] = 1'b0; rd[k] = '0; rb[k] = '0;
        end
        bus.s_req_i = '0; bus.s_add_i = '0; bus.s_wen_i = '0; bus.s_wdata_i = '0; bus.s_be_i = '0;
        bus.m_gnt_i = 1'b0; bus.m_r_valid_i = 1'b0; bus.m_r_rdata_i = '0; bus.m_r_opc_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("init_outstanding", 64'(outstanding), 64'(0));
        chk("init_err", 64'(err), 64'(0));
        chk("init_m_req", 64'(bus.m_req_o), 64'(0));
        chk("init_s_gnt", 64'(bus.s_gnt_o), 64'(0));
        chk("init_s_r_valid", 64'(bus.s_r_valid_o), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;

        // response with nothing outstanding: sticky error, cleared only by reset
        cycle(0, 0, 0, 1'b1);
        repeat (3) cycle(0, 0, 0, 1'b0);
        apply_reset();

        // fill the ID FIFO, observe backpressure, then release one slot
        repeat (8) cycle(100, 100, 0, 1'b0);
        cycle(100, 100, 100, 1'b0);
        repeat (2) cycle(100, 100, 0, 1'b0);
        drain();

        // saturated traffic with immediate responses, then mixed random traffic
        repeat (40) cycle(100, 100, 100, 1'b0);
        repeat (600) cycle(60, 60, 50, 1'b0);
        repeat (300) cycle(80, 30, 30, 1'b0);
        drain();

        // two outstanding plus a held lock, then async reset mid-cycle
        repeat (2) cycle(100, 100, 0, 1'b0);
        cycle(100, 0, 0, 1'b0);
        apply_reset();
        cycle(100, 0, 0, 1'b1);
        cycle(100, 100, 0, 1'b0);
        repeat (100) cycle(60, 60, 50, 1'b0);
        drain();
        repeat (4) cycle(0, 0, 0, 1'b0);

        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fc_l2_port_arbiter.md
Name: fc_l2_port_arbiter

Overview:
- Round-robin arbiter that shares one FC L2 TCDM master port between N TCDM-style requesters, e.g. FC core data plus HWPE ports.
- Sits between the FC subsystem requesters and the L2 interconnect.
- Tracks outstanding transactions in an in-order ID FIFO and steers each response back to the requester that issued it.
- Enforces TCDM request stability: once the arbiter presents a request to L2, that request is held until it is granted.

Parameters:
N_PORTS, 2, number of requester ports (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, depth of the response ID FIFO (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_req_i  in  N_PORTS  per-port request
s_add_i  in  N_PORTS*ADDR_WIDTH  per-port address
s_wen_i  in  N_PORTS  per-port write-enable, active low (1 = read)
s_wdata_i  in  N_PORTS*DATA_WIDTH  per-port write data
s_be_i  in  N_PORTS*DATA_WIDTH/8  per-port byte enables
s_gnt_o  out  N_PORTS  per-port grant
s_r_valid_o  out  N_PORTS  per-port response valid
s_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all ports
s_r_opc_o  out  1  response error, broadcast to all ports
m_req_o  out  1  L2 request
m_add_o  out  ADDR_WIDTH  L2 address
m_wen_o  out  1  L2 write-enable, active low
m_wdata_o  out  DATA_WIDTH  L2 write data
m_be_o  out  DATA_WIDTH/8  L2 byte enables
m_gnt_i  in  1  L2 grant
m_r_valid_i  in  1  L2 response valid; responses return in order
m_r_rdata_i  in  DATA_WIDTH  L2 response data
m_r_opc_i  in  1  L2 response error
outstanding_o  out  clog2(MAX_OUTSTANDING)+1  number of issued, unanswered transactions
err_o  out  1  sticky error: response received with empty ID FIFO

Behaviour:
- Reset: async on rst_ni low. rr_ptr=0, lock=0, FIFO empty, outstanding_o=0, err_o=0.
  - All outputs 0 while no requester is active: m_req_o, s_gnt_o, s_r_valid_o.
  - Master payload outputs are 0 when m_req_o=0.
- Winner selection (combinational):
  - If lock=1, winner = locked_id.
  - Else winner = first k with s_req_i[k]=1, searching from rr_ptr upward with wrap-around.
- Issue:
  - m_req_o = any s_req_i (or lock=1) AND FIFO not full.
  - m_add/wen/wdata/be_o = winner's fields.
  - s_gnt_o[winner] = m_gnt_i & m_req_o; all other s_gnt_o bits = 0.
  - Zero-latency grant path; no request registering.
- Lock:
  - If m_req_o=1 and m_gnt_i=0, set lock=1 and locked_id=winner.
  - Clear lock on a handshake (m_req_o & m_gnt_i).
  - While locked, winner does not change, even if higher-priority ports request.
- Round-robin: on a handshake, rr_ptr <= (winner+1) mod N_PORTS. No update otherwise.
- Response routing:
  - On handshake, push winner ID into the FIFO.
  - On m_r_valid_i, pop the FIFO head and assert s_r_valid_o[head] for that same cycle.
  - Pass m_r_rdata_i / m_r_opc_i through combinationally.
- FIFO full:
  - m_req_o=0 and no grants, even if a pop occurs in the same cycle.
  - Lock, if set, persists.
- Simultaneous push and pop (not full): both occur; outstanding_o is unchanged.
- Response with FIFO empty:
  - All s_r_valid_o stay 0; no pop.
  - err_o <= 1 and stays set until reset.
- outstanding_o: +1 on push, -1 on pop, unchanged on both or neither. Range 0..MAX_OUTSTANDING.
- Requester retracting s_req_i while locked is a protocol violation. Lock is still held until grant, and the grant goes to locked_id.
- Reset mid-operation:
  - All state is cleared.
  - L2 responses arriving later for pre-reset transactions set err_o.

Test Plan:
- N=2, ports 0 and 1 both reading continuously, m_gnt_i=1, m_r_valid_i one cycle after each grant -> grants alternate 0,1,0,1; each s_r_valid_o pulses at the port granted one cycle earlier; outstanding_o stays at most 1.
- Port 1 requests, m_gnt_i=0 for 3 cycles, port 0 asserts in cycle 2, grant in cycle 4 -> m_add_o holds port 1's address for all 4 cycles; s_gnt_o=2'b10 in cycle 4; port 0 is granted next.
- MAX_OUTSTANDING=4, 4 grants with no responses -> outstanding_o=4; m_req_o=0 while full; after one m_r_valid_i, m_req_o returns to 1 in the next cycle.
- Issue order 1,0,1 with in-order responses carrying rdata 0xA,0xB,0xC -> s_r_valid_o pulses 2'b10, 2'b01, 2'b10; s_r_rdata_o=0xA, 0xB, 0xC respectively.
- m_r_valid_i=1 with an empty FIFO -> s_r_valid_o=0; err_o=1 and stays 1 until rst_ni is asserted low.
- Assert rst_ni low asynchronously with 2 transactions outstanding and the lock set -> outstanding_o, err_o, m_req_o and s_gnt_o go to 0 immediately; after release, round-robin restarts at port 0.
